conv_pool_read_addr_gen: RTL and testbench

- Parametrised read-address generator for a CONVk×k + POOLp×p stage.
- Walks the input feature-map buffer in this order, innermost first: kernel taps → input channels → pool sub-positions → output-filter repeats → pooled column → pooled row.
- Adds a start/busy/done control handshake, valid/ready backpressure on the address stream, a runtime base address, and accumulate/pool boundary flags.
- Sits between the layer sequencer and the feature-map SRAM read port; its flags drive the MAC accumulator and the pooling comparator.

---
 rtl/conv_pool_read_addr_gen_pkg.sv | 34 +++
 rtl/conv_pool_read_addr_gen_wrap_counter.sv | 26 ++
 rtl/conv_pool_read_addr_gen.sv | 144 ++++++++++++++
 tb/tb_conv_pool_read_addr_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pool_read_addr_gen_pkg.sv
// Shared sizing helpers and FSM encoding for the conv/pool read-address generator.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsmState_t;

  // Bits needed to hold v distinct values; never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned calcOw(input int unsigned imgW, input int unsigned ksz,
                                         input int unsigned pool);
    return (pool == 0 || ksz > imgW) ? 0 : (imgW - ksz + 1) / pool;
  endfunction

  function automatic int unsigned calcOh(input int unsigned imgH, input int unsigned ksz,
                                         input int unsigned pool);
    return (pool == 0 || ksz > imgH) ? 0 : (imgH - ksz + 1) / pool;
  endfunction

  function automatic int unsigned calcPlane(input int unsigned imgW, input int unsigned imgH);
    return imgW * imgH;
  endfunction

endpackage

// File: rtl/conv_pool_read_addr_gen_wrap_counter.sv
// One mixed-radix digit: counts 0..MAXV, wraps to zero and reports carry-out.
module conv_wrap_counter #(
  parameter int unsigned WL   = 4,
  parameter int unsigned MAXV = 9
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iEN,
  output logic [WL-1:0] oCNT,
  output logic          oLAST,
  output logic          oWRAP
);

  assign oLAST = (oCNT == WL'(MAXV));
  assign oWRAP = iEN && oLAST;

  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      oCNT <= '0;
    end else if (iEN) begin
      oCNT <= oLAST ? '0 : oCNT + 1'b1;
    end
  end

endmodule

// File: rtl/conv_pool_read_addr_gen.sv
// Read-address generator for a CONV KSZxKSZ + POOL stage: walks taps, channels,
// pool sub-positions, filter repeats, pooled column and pooled row.
module conv_pool_read_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 14,
  parameter int unsigned IMG_H = 18,
  parameter int unsigned KSZ   = 3,
  parameter int unsigned POOL  = 2,
  parameter int unsigned NCH   = 1,
  parameter int unsigned NREP  = 112,
  parameter int unsigned AW    = 9
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [AW-1:0] iBASE,
  input  logic          iREADY,
  output logic          oVALID,
  output logic [AW-1:0] oADDR,
  output logic          oACC_LAST,
  output logic          oPOOL_LAST,
  output logic          oBUSY,
  output logic          oDONE
);

  localparam int unsigned OW    = calcOw(IMG_W, KSZ, POOL);
  localparam int unsigned OH    = calcOh(IMG_H, KSZ, POOL);
  localparam int unsigned PLANE = calcPlane(IMG_W, IMG_H);
  localparam int unsigned NDIG  = 8;

  // Digit order, innermost first: kx, ky, c, dx, dy, r, ox, oy.
  localparam int unsigned DIG_MAX  [NDIG] = '{KSZ - 1, KSZ - 1, NCH - 1, POOL - 1,
                                              POOL - 1, NREP - 1, OW - 1, OH - 1};
  localparam int unsigned DIG_STEP [NDIG] = '{1, IMG_W, PLANE, 1, IMG_W, 0, POOL, POOL * IMG_W};

  if (KSZ > IMG_W || KSZ > IMG_H) begin : gChkKsz
    $error("conv_pool_read_addr_gen: kernel larger than input map");
  end
  if (OW < 1 || OH < 1) begin : gChkOut
    $error("conv_pool_read_addr_gen: pooled output map is empty");
  end
  if (NCH < 1 || NREP < 1 || POOL < 1) begin : gChkCnt
    $error("conv_pool_read_addr_gen: NCH, NREP and POOL must be at least 1");
  end

  fsmState_t     state;
  logic [AW-1:0] base;
  logic [AW-1:0] off     [NDIG];
  logic [AW-1:0] offNext [NDIG];
  logic [AW-1:0] addrNext;
  logic [NDIG:0] en;
  logic [NDIG-1:0] last;
  logic          fire;
  logic          startOk;

  assign fire    = oVALID && iREADY;
  assign startOk = (state == IDLE) && iSTART;
  assign en[0]   = fire;

  // Each digit carries a running address offset (count*step) so the address is a
  // plain sum of registers; a wrapping digit zeroes its offset instead of multiplying.
  for (genvar g = 0; g < NDIG; g++) begin : gDig
    localparam int unsigned WL = clog2(DIG_MAX[g] + 1);
    logic [WL-1:0] cnt;

    conv_wrap_counter #(
      .WL  (WL),
      .MAXV(DIG_MAX[g])
    ) uCnt (
      .iCLK (iCLK),
      .iRST (iRST),
      .iCLR (startOk),
      .iEN  (en[g]),
      .oCNT (cnt),
      .oLAST(last[g]),
      .oWRAP(en[g+1])
    );

    assign offNext[g] = !en[g] ? off[g] : (last[g] ? '0 : off[g] + AW'(DIG_STEP[g]));

    always_ff @(posedge iCLK) begin
      if (!iRST) assert (32'(cnt) <= DIG_MAX[g]);
    end
  end

  always_comb begin
    addrNext = base;
    for (int unsigned i = 0; i < NDIG; i++) addrNext = addrNext + offNext[i];
  end

  assign oACC_LAST  = oVALID && last[0] && last[1] && last[2];
  assign oPOOL_LAST = oACC_LAST && last[3] && last[4];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= IDLE;
      base   <= '0;
      oADDR  <= '0;
      oVALID <= 1'b0;
      oBUSY  <= 1'b0;
      oDONE  <= 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) off[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          oDONE <= 1'b0;
          if (iSTART) begin
            base   <= iBASE;
            oADDR  <= iBASE;
            oVALID <= 1'b1;
            oBUSY  <= 1'b1;
            state  <= RUN;
            for (int unsigned i = 0; i < NDIG; i++) off[i] <= '0;
          end
        end
        RUN: begin
          if (fire) begin
            for (int unsigned i = 0; i < NDIG; i++) off[i] <= offNext[i];
            oADDR <= addrNext;
            if (en[NDIG]) begin
              oVALID <= 1'b0;
              oBUSY  <= 1'b0;
              oDONE  <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          oDONE <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST && startOk)
      assert (64'(iBASE) + 64'(NCH) * 64'(PLANE) <= (64'd1 << AW))
      else $warning("conv_pool_read_addr_gen: base + channel span exceeds address space, addresses wrap");
  end

endmodule

// File: tb/tb_conv_pool_read_addr_gen.sv
// Directed bench for conv_pool_read_addr_gen: sequence, flags, backpressure, reset, restart.
module tb_conv_pool_read_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, rstB, startA, startB, rdy;
  logic [8:0] baseA;
  logic [9:0] baseB;
  logic       validA, accA, poolA, busyA, doneA;
  logic [8:0] addrA;
  logic       validB, accB, poolB, busyB, doneB;
  logic [9:0] addrB;

  // Reduced NREP keeps full jobs short; address pattern per repeat is unchanged.
  conv_pool_read_addr_gen #(.IMG_W(14), .IMG_H(18), .KSZ(3), .POOL(2), .NCH(1), .NREP(2), .AW(9)) dutA (
    .iCLK(clk), .iRST(rstA), .iSTART(startA), .iBASE(baseA), .iREADY(rdy),
    .oVALID(validA), .oADDR(addrA), .oACC_LAST(accA), .oPOOL_LAST(poolA),
    .oBUSY(busyA), .oDONE(doneA));

  conv_pool_read_addr_gen #(.IMG_W(14), .IMG_H(18), .KSZ(3), .POOL(2), .NCH(2), .NREP(1), .AW(10)) dutB (
    .iCLK(clk), .iRST(rstB), .iSTART(startB), .iBASE(baseB), .iREADY(rdy),
    .oVALID(validB), .oADDR(addrB), .oACC_LAST(accB), .oPOOL_LAST(poolB),
    .oBUSY(busyB), .oDONE(doneB));

  logic       sel;
  logic       curValid, curAcc, curPool, curBusy, curDone;
  logic [9:0] curAddr;
  assign curValid = sel ? validB : validA;
  assign curAcc   = sel ? accB   : accA;
  assign curPool  = sel ? poolB  : poolA;
  assign curBusy  = sel ? busyB  : busyA;
  assign curDone  = sel ? doneB  : doneA;
  assign curAddr  = sel ? addrB  : {1'b0, addrA};

  int nTests = 0;
  int nFail  = 0;
  int capAddr[$];
  bit capAcc[$];
  bit capPool[$];
  int refAddr[$];
  bit refAcc[$];
  bit refPool[$];
  int hs, holdErr, nDone, doneGap;

  task automatic check(input string tag, input longint got, input longint exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic startJob(input bit useB, input int base);
    if (useB) begin baseB = 10'(base); startB = 1'b1; end
    else      begin baseA = 9'(base);  startA = 1'b1; end
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Runs one job to its oDONE pulse, capturing every handshake.
  task automatic runJob(input bit bp, input bit poke, input int budget);
    int cyc = 0;
    int lastFire = -100;
    bit held = 1'b0;
    bit seenDone = 1'b0;
    logic [11:0] heldVal = '0;
    capAddr.delete(); capAcc.delete(); capPool.delete();
    hs = 0; holdErr = 0; nDone = 0; doneGap = -1;
    while (!seenDone && cyc < budget) begin
      if (curDone) begin
        seenDone = 1'b1;
        nDone++;
        doneGap = cyc - lastFire;
      end else begin
        if (held && {curAddr, curAcc, curPool} != heldVal) holdErr++;
        rdy = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (poke) begin
          startA = (cyc % 40 == 7);
          baseA  = 9'(100 + cyc);
        end
        held    = curValid && !rdy;
        heldVal = {curAddr, curAcc, curPool};
        if (curValid && rdy) begin
          capAddr.push_back(int'(curAddr));
          capAcc.push_back(curAcc);
          capPool.push_back(curPool);
          hs++;
          lastFire = cyc;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    startA = 1'b0;
    rdy = 1'b1;
    check("job_done_within_budget", seenDone, 1);
    check("valid_low_at_done", curValid, 0);
    check("busy_low_at_done", curBusy, 0);
  endtask

  int tIdx  [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 19, 28, 36, 37, 73, 3456};
  int tAddr [16] = '{0, 1, 2, 14, 15, 16, 28, 29, 30, 1, 14, 15, 45, 0, 2, 251};

  initial begin
    int seqErr;
    int n;
    int guard;
    rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0; rdy = 1'b1;
    baseA = '0; baseB = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0; rstB = 1'b0;
    @(posedge clk); #1;

    check("rst_valid", validA, 0);
    check("rst_addr", addrA, 0);
    check("rst_acc", accA, 0);
    check("rst_pool", poolA, 0);
    check("rst_busy", busyA, 0);
    check("rst_done", doneA, 0);

    // Reference job, iREADY held high
    startJob(1'b0, 0);
    check("first_valid", curValid, 1);
    check("first_busy", curBusy, 1);
    runJob(1'b0, 1'b0, 5000);
    check("ref_hs_total", hs, 3456);
    check("ref_done_gap", doneGap, 1);
    for (int i = 0; i < 16; i++)
      check($sformatf("ref_addr_hs%0d", tIdx[i]), capAddr[tIdx[i] - 1], tAddr[i]);
    for (int i = 0; i < 9; i++)
      check($sformatf("ref_acc_hs%0d", i + 1), capAcc[i], (i == 8) ? 1 : 0);
    check("ref_pool_hs9", capPool[8], 0);
    check("ref_acc_hs36", capAcc[35], 1);
    check("ref_pool_hs36", capPool[35], 1);
    check("ref_pool_hs72", capPool[71], 1);
    refAddr = capAddr; refAcc = capAcc; refPool = capPool;
    @(posedge clk); #1;
    check("ref_done_one_cycle", doneA, 0);
    check("ref_idle_busy", busyA, 0);

    // Same job under 30% ready duty
    startJob(1'b0, 0);
    runJob(1'b1, 1'b0, 20000);
    check("bp_hs_total", hs, 3456);
    seqErr = 0;
    for (int i = 0; i < refAddr.size(); i++) begin
      if (i >= capAddr.size()) seqErr++;
      else if (capAddr[i] != refAddr[i] || capAcc[i] != refAcc[i] || capPool[i] != refPool[i]) seqErr++;
    end
    check("bp_sequence_mismatches", seqErr, 0);
    check("bp_hold_violations", holdErr, 0);

    // Two channels, one repeat, base 10
    sel = 1'b1;
    startJob(1'b1, 10);
    runJob(1'b0, 1'b0, 5000);
    check("nch2_hs_total", hs, 3456);
    check("nch2_addr_hs1", capAddr[0], 10);
    check("nch2_addr_hs9", capAddr[8], 40);
    check("nch2_addr_hs10", capAddr[9], 262);
    check("nch2_addr_last", capAddr[3455], 513);
    for (int i = 0; i < 18; i++)
      check($sformatf("nch2_acc_hs%0d", i + 1), capAcc[i], (i == 17) ? 1 : 0);
    check("nch2_pool_hs18", capPool[17], 0);
    check("nch2_pool_hs72", capPool[71], 1);
    sel = 1'b0;

    // Reset in the middle of a job
    startJob(1'b0, 0);
    n = 0;
    guard = 0;
    while (n < 500 && guard < 2000) begin
      if (validA && rdy) n++;
      if (n == 500) rstA = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    check("midrst_reached_hs500", n, 500);
    check("midrst_valid", validA, 0);
    check("midrst_busy", busyA, 0);
    check("midrst_addr", addrA, 0);
    check("midrst_acc", accA, 0);
    rstA = 1'b0;
    startJob(1'b0, 7);
    check("restart_valid", validA, 1);
    check("restart_addr", addrA, 7);
    check("restart_acc", accA, 0);
    rstA = 1'b1;
    @(posedge clk); #1;
    rstA = 1'b0;

    // iSTART pulses with other bases while running
    startJob(1'b0, 3);
    runJob(1'b0, 1'b1, 5000);
    check("poke_hs_total", hs, 3456);
    check("poke_addr_hs1", capAddr[0], 3);
    check("poke_addr_hs37", capAddr[36], 3);
    check("poke_addr_last", capAddr[3455], 254);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (doneA) nDone++;
    end
    check("poke_single_done", nDone, 1);
    check("poke_idle_valid", validA, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
